// File: rtl/trace_request_tracker.sv
// -----------------------------------------------------------------------------
// trace_request_tracker
//
// In-order tracker for trace-driven memory requests. It sits between the trace
// repository and the data cache. Each accepted {trace_index, mem_addr} entry
// goes into an ENTRIES-deep circular table and is sent to memory with its slot
// number as the tag. Completions can come back in any order, by tag. Entries
// still retire strictly in allocation order.
//
// Optional feature (compile-time macro TRACKER_MERGE_EN):
//   When the macro is defined, a new entry whose address matches an in-flight
//   entry (MAKE_REQUEST or WAIT_FOR_PROCESSING) does not issue its own request.
//   It attaches to the oldest matching owner and completes on that owner's
//   response. When the macro is undefined, every entry owns itself.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   alloc_valid/ready/addr/index   new entry offer (ready = !full)
//   req_valid/ready/addr/tag       memory request (registered, stable while stalled)
//   resp_valid/tag                 completion strobe by owner tag, no backpressure
//   retire_valid/ready/index/addr  head entry hand-off to the consumer
//   count, full, empty             occupancy
//   resp_err                       sticky: a response hit a slot not in WAIT
//
// Slot states
//   state              | meaning
//   S_FREE             | slot unused
//   S_MAKE             | allocated, request not yet accepted by memory
//   S_WAIT             | request outstanding (own or owner's)
//   S_RET              | completed, waiting to reach head and retire
// -----------------------------------------------------------------------------
module trace_request_tracker #(
  parameter int ENTRIES     = 4,
  parameter int ADDR_WIDTH  = 32,
  parameter int INDEX_WIDTH = 17,
  localparam int TAG_W      = $clog2(ENTRIES)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   alloc_valid,
  output logic                   alloc_ready,
  input  logic [ADDR_WIDTH-1:0]  alloc_addr,
  input  logic [INDEX_WIDTH-1:0] alloc_index,
  output logic                   req_valid,
  input  logic                   req_ready,
  output logic [ADDR_WIDTH-1:0]  req_addr,
  output logic [TAG_W-1:0]       req_tag,
  input  logic                   resp_valid,
  input  logic [TAG_W-1:0]       resp_tag,
  output logic                   retire_valid,
  input  logic                   retire_ready,
  output logic [INDEX_WIDTH-1:0] retire_index,
  output logic [ADDR_WIDTH-1:0]  retire_addr,
  output logic [TAG_W:0]         count,
  output logic                   full,
  output logic                   empty,
  output logic                   resp_err
);

  localparam logic [1:0] S_FREE = 2'd0;
  localparam logic [1:0] S_MAKE = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_RET  = 2'd3;

  localparam logic [TAG_W:0]   FULL_CNT = (TAG_W+1)'(ENTRIES);
  localparam logic [TAG_W-1:0] ONE_TAG  = TAG_W'(1);

  logic [1:0]             state_q [ENTRIES];
  logic [1:0]             state_d [ENTRIES];
  logic [TAG_W-1:0]       owner_q [ENTRIES];
  logic [TAG_W-1:0]       owner_d [ENTRIES];
  logic [ADDR_WIDTH-1:0]  addr_q  [ENTRIES];
  logic [ADDR_WIDTH-1:0]  addr_d  [ENTRIES];
  logic [INDEX_WIDTH-1:0] index_q [ENTRIES];
  logic [INDEX_WIDTH-1:0] index_d [ENTRIES];

  logic [TAG_W-1:0] head_q, head_d;
  logic [TAG_W-1:0] tail_q, tail_d;
  logic [TAG_W:0]   count_q, count_d;
  logic             req_valid_q, req_valid_d;
  logic [TAG_W-1:0] req_tag_q, req_tag_d;
  logic             retire_valid_q, retire_valid_d;
  logic             err_q, err_d;
  logic [TAG_W-1:0] scan_slot;

  logic alloc_fire, req_fire, retire_fire;

  assign alloc_ready  = (count_q != FULL_CNT);
  assign alloc_fire   = alloc_valid && alloc_ready;
  assign req_fire     = req_valid_q && req_ready;
  assign retire_fire  = retire_valid_q && retire_ready;

  assign req_valid    = req_valid_q;
  assign req_tag      = req_tag_q;
  assign req_addr     = addr_q[req_tag_q];
  assign retire_valid = retire_valid_q;
  assign retire_index = index_q[head_q];
  assign retire_addr  = addr_q[head_q];
  assign count        = count_q;
  assign full         = (count_q == FULL_CNT);
  assign empty        = (count_q == '0);
  assign resp_err     = err_q;

`ifdef TRACKER_MERGE_EN
  // Oldest in-flight entry with the same address, scanning from head.
  // RET and FREE slots never match.
  logic             merge_hit;
  logic             merge_done;
  logic [TAG_W-1:0] merge_owner;
  logic [TAG_W-1:0] merge_slot;

  always_comb begin
    merge_hit   = 1'b0;
    merge_done  = 1'b0;
    merge_owner = '0;
    merge_slot  = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      merge_slot = head_q + TAG_W'(i);
      if (!merge_hit && addr_q[merge_slot] == alloc_addr &&
          (state_q[merge_slot] == S_MAKE || state_q[merge_slot] == S_WAIT)) begin
        merge_hit   = 1'b1;
        merge_owner = owner_q[merge_slot];
        // The owner's response lands in the same cycle: the new slot is born complete.
        merge_done  = resp_valid && state_q[merge_slot] == S_WAIT &&
                      owner_q[merge_slot] == resp_tag;
      end
    end
  end
`endif

  always_comb begin
    state_d        = state_q;
    owner_d        = owner_q;
    addr_d         = addr_q;
    index_d        = index_q;
    head_d         = head_q;
    tail_d         = tail_q;
    err_d          = err_q;
    count_d        = count_q;
    req_valid_d    = 1'b0;
    req_tag_d      = req_tag_q;
    retire_valid_d = 1'b0;
    scan_slot      = '0;

    // Completion. This is evaluated on the current state, so a response that
    // races its own request handshake sees MAKE: it is flagged and then lost.
    if (resp_valid) begin
      if (state_q[resp_tag] != S_WAIT) err_d = 1'b1;
      for (int i = 0; i < ENTRIES; i++) begin
        if (state_q[i] == S_WAIT && owner_q[i] == resp_tag) state_d[i] = S_RET;
      end
    end

    if (req_fire) state_d[req_tag_q] = S_WAIT;

    if (retire_fire) begin
      state_d[head_q] = S_FREE;
      head_d          = head_q + ONE_TAG;
    end

    // The tail slot is FREE whenever the table is not full. It cannot be the
    // slot freed this cycle, because that would need count == ENTRIES.
    if (alloc_fire) begin
      addr_d[tail_q]  = alloc_addr;
      index_d[tail_q] = alloc_index;
      tail_d          = tail_q + ONE_TAG;
`ifdef TRACKER_MERGE_EN
      if (merge_hit) begin
        state_d[tail_q] = merge_done ? S_RET : S_WAIT;
        owner_d[tail_q] = merge_owner;
      end else begin
        state_d[tail_q] = S_MAKE;
        owner_d[tail_q] = tail_q;
      end
`else
      state_d[tail_q] = S_MAKE;
      owner_d[tail_q] = tail_q;
`endif
    end

    case ({alloc_fire, retire_fire})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    // A stalled request holds its slot. Otherwise present the oldest MAKE
    // slot of the next state, so a fresh alloc shows up one cycle later.
    if (req_valid_q && !req_ready) begin
      req_valid_d = 1'b1;
    end else begin
      for (int i = 0; i < ENTRIES; i++) begin
        scan_slot = head_d + TAG_W'(i);
        if (!req_valid_d && state_d[scan_slot] == S_MAKE) begin
          req_valid_d = 1'b1;
          req_tag_d   = scan_slot;
        end
      end
    end

    retire_valid_d = (state_d[head_d] == S_RET);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        state_q[i] <= S_FREE;
        owner_q[i] <= '0;
        addr_q[i]  <= '0;
        index_q[i] <= '0;
      end
      head_q         <= '0;
      tail_q         <= '0;
      count_q        <= '0;
      req_valid_q    <= 1'b0;
      req_tag_q      <= '0;
      retire_valid_q <= 1'b0;
      err_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      owner_q        <= owner_d;
      addr_q         <= addr_d;
      index_q        <= index_d;
      head_q         <= head_d;
      tail_q         <= tail_d;
      count_q        <= count_d;
      req_valid_q    <= req_valid_d;
      req_tag_q      <= req_tag_d;
      retire_valid_q <= retire_valid_d;
      err_q          <= err_d;
    end
  end

endmodule
